// File: rtl/qsys_block_nios2e_cpu_debug_pkg.sv
// Shared constants and types for the Nios II debug monitor memory block.
package qsys_block_nios2e_cpu_debug_pkg;

  // JTAG command word layout
  localparam int unsigned JDO_W         = 38;
  localparam int unsigned JDO_CLR_RDY   = 35;
  localparam int unsigned JDO_CLR_ERR   = 34;
  localparam int unsigned JDO_RD_EN     = 33;
  localparam int unsigned JDO_ADDR_LSB  = 17;
  localparam int unsigned JDO_WDATA_LSB = 3;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // CPU read sequencing: accept, RAM access, present data
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRdRam = 2'd1,
    StRdOut = 2'd2
  } cpu_rd_state_e;

endpackage

// File: rtl/qsys_block_nios2e_cpu_debug_mem_ram.sv
// Single-port synchronous monitor RAM with byte-lane writes and one clock of read latency.
// Contents are deliberately not reset.
module qsys_block_nios2e_cpu_debug_mem_ram
  import qsys_block_nios2e_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write or registered read on an enabled access
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(BE_W); i++) begin
          if (be_i[i]) begin
            mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/qsys_block_nios2e_cpu_debug_mem.sv
// Debug monitor memory: owns the monitor RAM and ready/error flags, arbitrates the RAM
// between JTAG commands (always win) and the CPU Avalon-MM debug slave.
// DEPTH must equal 2**ADDR_W; the JTAG address counter relies on natural wrap.
module qsys_block_nios2e_cpu_debug_mem
  import qsys_block_nios2e_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [BE_W-1:0]   avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // Strobes resolved to one-at-a-time with priority a > b > no_action_a
  logic take_a;
  logic take_b;
  logic take_na;
  logic jtag_busy;
  logic jtag_rd;

  assign take_a    = take_action_ocimem_a;
  assign take_b    = take_action_ocimem_b & ~take_action_ocimem_a;
  assign take_na   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign jtag_busy = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jtag_rd   = (take_a & jdo[JDO_RD_EN]) | take_na;

  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_wdata;
  assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata = jdo[JDO_WDATA_LSB +: DATA_W];

  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_CLR_RDY+1], jdo[JDO_WDATA_LSB-1:0]};

  // State
  logic              rst_done_q;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d, jtag_addr_inc;
  logic              jtag_rd_pend_q;
  logic [DATA_W-1:0] mon_q;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  cpu_rd_state_e     cpu_state_q, cpu_state_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  // CPU-side decode
  logic cpu_reg_sel;
  logic cpu_wr;
  logic cpu_rd;
  logic cpu_ram_go;
  logic reg_wr;

  assign cpu_reg_sel = avs_address[ADDR_W];
  assign cpu_wr      = avs_write;
  assign cpu_rd      = avs_read & ~avs_write;

  // RAM port
  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign jtag_addr_inc = jtag_addr_q + 1'b1;

  // RAM port mux: any JTAG strobe owns the port, otherwise an accepted CPU access
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = {BE_W{1'b1}};
    ram_addr  = jtag_addr_q;
    ram_wdata = jdo_wdata;
    if (take_a) begin
      ram_en   = jdo[JDO_RD_EN];
      ram_addr = jdo_addr;
    end else if (take_b) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end else if (take_na) begin
      // Advance-then-read, so a read-load followed by no_action streams consecutive words
      ram_en   = 1'b1;
      ram_addr = jtag_addr_inc;
    end else if (cpu_ram_go) begin
      ram_en    = 1'b1;
      ram_we    = cpu_wr;
      ram_be    = avs_byteenable;
      ram_addr  = avs_address[ADDR_W-1:0];
      ram_wdata = avs_writedata;
    end
  end

  qsys_block_nios2e_cpu_debug_mem_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // JTAG address counter next state
  always_comb begin
    jtag_addr_d = jtag_addr_q;
    if (take_a) begin
      jtag_addr_d = jdo_addr;
    end else if (take_b || take_na) begin
      jtag_addr_d = jtag_addr_inc;
    end
  end

  // CPU slave FSM: wait states, RAM grant, read data and register-space access
  always_comb begin
    cpu_state_d     = cpu_state_q;
    cpu_rdata_d     = cpu_rdata_q;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    cpu_ram_go      = 1'b0;
    reg_wr          = 1'b0;
    unique case (cpu_state_q)
      StIdle: begin
        if (!rst_done_q) begin
          avs_waitrequest = 1'b1;
        end else if (cpu_reg_sel && (cpu_rd || cpu_wr)) begin
          avs_waitrequest = 1'b0;
          reg_wr          = cpu_wr;
          if (cpu_rd) begin
            avs_readdata = {{(DATA_W-2){1'b0}}, err_q, rdy_q};
          end
        end else if (cpu_wr) begin
          avs_waitrequest = jtag_busy;
          cpu_ram_go      = ~jtag_busy;
        end else if (cpu_rd) begin
          avs_waitrequest = 1'b1;
          if (!jtag_busy) begin
            cpu_ram_go  = 1'b1;
            cpu_state_d = StRdRam;
          end
        end else begin
          avs_waitrequest = 1'b0;
        end
      end
      StRdRam: begin
        cpu_rdata_d = ram_rdata;
        cpu_state_d = StRdOut;
      end
      StRdOut: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = cpu_rdata_q;
        cpu_state_d     = StIdle;
      end
      default: begin
        cpu_state_d = StIdle;
      end
    endcase
  end

  // Flag next state: JTAG clears are applied after CPU sets so they win
  always_comb begin
    rdy_d = rdy_q;
    err_d = err_q;
    if (reg_wr) begin
      if (avs_writedata[0]) rdy_d = 1'b1;
      if (avs_writedata[1]) err_d = 1'b1;
    end
    if (take_a) begin
      if (jdo[JDO_CLR_RDY]) rdy_d = 1'b0;
      if (jdo[JDO_CLR_ERR]) err_d = 1'b0;
    end
  end

  // Control and JTAG state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_done_q     <= 1'b0;
      jtag_addr_q    <= '0;
      jtag_rd_pend_q <= 1'b0;
      rdy_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      rst_done_q     <= 1'b1;
      jtag_addr_q    <= jtag_addr_d;
      jtag_rd_pend_q <= jtag_rd;
      rdy_q          <= rdy_d;
      err_q          <= err_d;
    end
  end

  // MonDReg captures RAM output the clock after a JTAG read was issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_q <= '0;
    end else if (jtag_rd_pend_q) begin
      mon_q <= ram_rdata;
    end
  end

  // CPU read FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_state_q <= StIdle;
      cpu_rdata_q <= '0;
    end else begin
      cpu_state_q <= cpu_state_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign MonDReg       = mon_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_qsys_block_nios2e_cpu_debug_mem.sv
// Bench for the debug monitor memory: directed sequences, a flag table and random traffic
// checked against a word-array reference model.
module tb_qsys_block_nios2e_cpu_debug_mem;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W:0]   avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  always #5 clk = ~clk;

  qsys_block_nios2e_cpu_debug_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model
  logic [31:0] mem_m [DEPTH];
  logic        rdy_m, err_m;
  logic [7:0]  jaddr_m;
  logic [31:0] mon_m;

  typedef struct {
    logic       cpu_wr;
    logic [1:0] set;   // {error, ready} bits written by the CPU
    logic [1:0] clr;   // {error, ready} clears from JTAG in the same cycle
    logic [1:0] exp;   // {error, ready} afterwards
  } flag_vec_t;

  flag_vec_t fvec [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_load(input logic [7:0] a, input logic cr, input logic ce, input logic rd);
    jdo = '0;
    jdo[24:17] = a;
    jdo[35] = cr;
    jdo[34] = ce;
    jdo[33] = rd;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    jaddr_m = a;
    if (cr) rdy_m = 1'b0;
    if (ce) err_m = 1'b0;
  endtask

  task automatic jtag_write(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    mem_m[jaddr_m] = d;
    jaddr_m = jaddr_m + 8'd1;
  endtask

  task automatic jtag_read_at(input logic [7:0] a);
    jtag_load(a, 1'b0, 1'b0, 1'b1);
    chk("mondreg_hold_load", MonDReg, mon_m);
    mon_m = mem_m[a];
    cyc();
    chk("mondreg_after_load", MonDReg, mon_m);
  endtask

  task automatic jtag_next();
    take_no_action_ocimem_a = 1'b1;
    cyc();
    take_no_action_ocimem_a = 1'b0;
    chk("mondreg_hold_next", MonDReg, mon_m);
    jaddr_m = jaddr_m + 8'd1;
    mon_m = mem_m[jaddr_m];
    cyc();
    chk("mondreg_after_next", MonDReg, mon_m);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int waits);
    bit done;
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    waits = 0;
    done = 0;
    for (int i = 0; i < 16 && !done; i++) begin
      #1;
      if (!avs_waitrequest) done = 1;
      else waits++;
      cyc();
    end
    avs_write = 1'b0;
    if (done) begin
      if (!a[8]) begin
        mem_m[a[7:0]] = merge(mem_m[a[7:0]], d, be);
      end else begin
        if (d[0]) rdy_m = 1'b1;
        if (d[1]) err_m = 1'b1;
      end
    end
  endtask

  task automatic cpu_read(input logic [8:0] a, output logic [31:0] d, output int waits);
    bit done;
    avs_address = a;
    avs_read = 1'b1;
    waits = 0;
    done = 0;
    d = 'x;
    for (int i = 0; i < 16 && !done; i++) begin
      #1;
      if (!avs_waitrequest) begin
        done = 1;
        d = avs_readdata;
      end else begin
        waits++;
      end
      cyc();
    end
    avs_read = 1'b0;
  endtask

  task automatic check_ram(input logic [7:0] a);
    logic [31:0] d;
    int w;
    cpu_read({1'b0, a}, d, w);
    chk("cpu_ram_read_data", d, mem_m[a]);
    chk("cpu_ram_read_waits", 32'(w), 32'd2);
  endtask

  task automatic check_reg();
    logic [31:0] d;
    int w;
    logic [7:0] lo;
    lo = 8'($urandom_range(0, 255));
    cpu_read({1'b1, lo}, d, w);
    chk("cpu_reg_read_data", d, {30'b0, err_m, rdy_m});
    chk("cpu_reg_read_waits", 32'(w), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          w;
    logic [31:0] r;

    fvec[0] = '{cpu_wr: 1'b1, set: 2'b11, clr: 2'b00, exp: 2'b11};
    fvec[1] = '{cpu_wr: 1'b1, set: 2'b01, clr: 2'b01, exp: 2'b10};
    fvec[2] = '{cpu_wr: 1'b1, set: 2'b00, clr: 2'b00, exp: 2'b10};
    fvec[3] = '{cpu_wr: 1'b1, set: 2'b01, clr: 2'b00, exp: 2'b11};
    fvec[4] = '{cpu_wr: 1'b0, set: 2'b00, clr: 2'b10, exp: 2'b01};
    fvec[5] = '{cpu_wr: 1'b1, set: 2'b10, clr: 2'b10, exp: 2'b01};
    fvec[6] = '{cpu_wr: 1'b1, set: 2'b11, clr: 2'b11, exp: 2'b00};
    fvec[7] = '{cpu_wr: 1'b1, set: 2'b10, clr: 2'b00, exp: 2'b10};
    fvec[8] = '{cpu_wr: 1'b0, set: 2'b00, clr: 2'b11, exp: 2'b00};

    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    rdy_m = 1'b0;
    err_m = 1'b0;
    jaddr_m = '0;
    mon_m = '0;

    // Reset state
    reset = 1'b1;
    #2;
    chk("reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("reset_readdata", avs_readdata, 32'd0);
    chk("reset_mondreg", MonDReg, 32'd0);
    chk("reset_flags", {30'b0, monitor_error, monitor_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
    chk("release_waitrequest", 32'(avs_waitrequest), 32'd0);

    // Fill the whole RAM so every later read has a defined value
    jtag_load(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) jtag_write($urandom);

    // JTAG load and write, then streamed readback
    jtag_load(8'h10, 1'b0, 1'b0, 1'b0);
    jtag_write(32'hDEADBEEF);
    jtag_write(32'h12345678);
    check_ram(8'h10);
    check_ram(8'h11);
    jdo = '0;
    jdo[24:17] = 8'h10;
    jdo[33] = 1'b1;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    chk("readback_hold", MonDReg, mon_m);
    cyc();
    take_no_action_ocimem_a = 1'b0;
    chk("readback_first", MonDReg, 32'hDEADBEEF);
    cyc();
    chk("readback_second", MonDReg, 32'h12345678);
    jaddr_m = 8'h11;
    mon_m = 32'h12345678;

    // Wrap of the JTAG address counter
    cpu_write(9'h002, 32'h0BADF00D, 4'hF, w);
    chk("cpu_write_waits", 32'(w), 32'd0);
    jtag_load(8'hFF, 1'b0, 1'b0, 1'b0);
    jtag_write(32'hAAAA0001);
    jtag_write(32'hBBBB0002);
    check_ram(8'hFF);
    check_ram(8'h00);
    jtag_next();
    chk("wrap_next_reads_02", MonDReg, 32'h0BADF00D);

    // CPU write colliding with a JTAG write
    cpu_write(9'h020, 32'h11223344, 4'hF, w);
    jtag_load(8'h21, 1'b0, 1'b0, 1'b0);
    avs_address = 9'h020;
    avs_writedata = 32'hA5A5A5A5;
    avs_byteenable = 4'b0011;
    avs_write = 1'b1;
    jdo = '0;
    jdo[34:3] = 32'h55667788;
    take_action_ocimem_b = 1'b1;
    #1;
    chk("conflict_wait_high", 32'(avs_waitrequest), 32'd1);
    cyc();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    #1;
    chk("conflict_wait_low", 32'(avs_waitrequest), 32'd0);
    cyc();
    avs_write = 1'b0;
    mem_m[8'h21] = 32'h55667788;
    mem_m[8'h20] = 32'h1122A5A5;
    jaddr_m = 8'h22;
    check_ram(8'h20);
    check_ram(8'h21);

    // Flag table: CPU sets against simultaneous JTAG clears
    foreach (fvec[i]) begin
      r = $urandom;
      r[1:0] = fvec[i].set;
      avs_address = {1'b1, 8'($urandom_range(0, 255))};
      avs_writedata = r;
      avs_byteenable = 4'hF;
      avs_write = fvec[i].cpu_wr;
      jdo = '0;
      jdo[24:17] = jaddr_m;
      jdo[35] = fvec[i].clr[0];
      jdo[34] = fvec[i].clr[1];
      take_action_ocimem_a = |fvec[i].clr;
      #1;
      chk("flag_write_wait", 32'(avs_waitrequest), 32'd0);
      cyc();
      avs_write = 1'b0;
      take_action_ocimem_a = 1'b0;
      jdo = '0;
      rdy_m = fvec[i].exp[0];
      err_m = fvec[i].exp[1];
      chk("flag_ports", {30'b0, monitor_error, monitor_ready}, {30'b0, fvec[i].exp});
      check_reg();
    end

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: begin
          jtag_load(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          jtag_write($urandom);
        end
        1: jtag_read_at(a);
        2: jtag_next();
        3: begin
          cpu_write({1'b0, a}, $urandom, 4'($urandom_range(0, 15)), w);
          chk("rand_cpu_write_waits", 32'(w), 32'd0);
        end
        4: check_ram(a);
        default: begin
          r = $urandom;
          cpu_write({1'b1, a}, r, 4'hF, w);
          chk("rand_reg_write_waits", 32'(w), 32'd0);
          check_reg();
        end
      endcase
    end

    // Reset drops a pending JTAG read
    cpu_write(9'h030, 32'hFEEDFACE, 4'hF, w);
    jtag_read_at(8'h30);
    cpu_write(9'h100, 32'h3, 4'hF, w);
    jdo = '0;
    jdo[24:17] = 8'h31;
    jdo[33] = 1'b1;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
    reset = 1'b1;
    #1;
    chk("rst_jtag_mondreg", MonDReg, 32'd0);
    chk("rst_jtag_flags", {30'b0, monitor_error, monitor_ready}, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    chk("rst_jtag_mondreg_after", MonDReg, 32'd0);
    rdy_m = 1'b0;
    err_m = 1'b0;
    jaddr_m = 8'h00;
    mon_m = 32'd0;

    // Reset while a CPU read sits in the RAM stage
    cpu_write(9'h100, 32'h3, 4'hF, w);
    avs_address = 9'h020;
    avs_read = 1'b1;
    #1;
    chk("rst_rd_accept_wait", 32'(avs_waitrequest), 32'd1);
    cyc();
    #1;
    chk("rst_rd_ram_wait", 32'(avs_waitrequest), 32'd1);
    reset = 1'b1;
    avs_read = 1'b0;
    #1;
    chk("rst_rd_wait", 32'(avs_waitrequest), 32'd1);
    chk("rst_rd_readdata", avs_readdata, 32'd0);
    chk("rst_rd_flags", {30'b0, monitor_error, monitor_ready}, 32'd0);
    chk("rst_rd_mondreg", MonDReg, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_rd_release_wait", 32'(avs_waitrequest), 32'd0);
    chk("rst_rd_no_stale", avs_readdata, 32'd0);
    rdy_m = 1'b0;
    err_m = 1'b0;
    check_ram(8'h20);
    check_reg();
    jtag_next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
